scan_mux_nx1: RTL and testbench

Parametrised N-to-1 multiplexer with a registered output, a valid/ready output handshake and an automatic channel-scan mode. It generalises the combinational n×1 select mux in width (DATA_W bits per channel) and behaviour. On one start pulse it delivers either a single selected channel (manual mode) or every enabled channel in ascending order (scan mode). It sits between parallel sources and a single serial consumer, for example a display driver or a time-division transmit path.

---
 rtl/scan_mux_pkg.sv | 19 +
 rtl/scan_mux_nx1_if.sv | 49 ++++
 rtl/scan_mux_nx1_next_ch_find.sv | 35 +++
 rtl/scan_mux_nx1.sv | 123 ++++++++++++
 tb/tb_scan_mux_nx1.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
// Shared types and constants for the scan_mux_nx1 channel multiplexer.
//   state_t      : FSM state type, with constants IDLE / OUT / FIN
//   MODE_MANUAL  : deliver the single channel named by sel_in
//   MODE_SCAN    : deliver every enabled channel in ascending order
// -----------------------------------------------------------------------------
package scan_mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t OUT  = 2'd1;
  localparam state_t FIN  = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_nx1_if.sv
// -----------------------------------------------------------------------------
// scan_mux_nx1_if
// Request/response bundle between the parallel sources/consumer and the mux.
// Optional macro: SCAN_MASK_EN adds the en_mask signal.
//   in        : N*DATA_W channel data, channel i at in[i*DATA_W +: DATA_W]
//   mode      : 0 manual, 1 scan (sampled on start)
//   sel_in    : manual channel index (sampled on start)
//   en_mask   : per-channel scan enable (SCAN_MASK_EN only)
//   start     : single-cycle request
//   out_ready : consumer accepts y
//   y, y_ch   : registered beat data and its channel index
//   y_valid   : y / y_ch hold a beat
//   busy      : operation in progress
//   done      : one-cycle completion pulse
// Modports: master = request side, slave = the mux.
// -----------------------------------------------------------------------------
interface scan_mux_nx1_if #(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
);
  localparam int N = 2 ** SEL_W;

  logic [N*DATA_W-1:0] in;
  logic                mode;
  logic [SEL_W-1:0]    sel_in;
`ifdef SCAN_MASK_EN
  logic [N-1:0]        en_mask;
`endif
  logic                start;
  logic                out_ready;
  logic [DATA_W-1:0]   y;
  logic [SEL_W-1:0]    y_ch;
  logic                y_valid;
  logic                busy;
  logic                done;

`ifdef SCAN_MASK_EN
  modport master (output in, mode, sel_in, en_mask, start, out_ready,
                  input  y, y_ch, y_valid, busy, done);
  modport slave  (input  in, mode, sel_in, en_mask, start, out_ready,
                  output y, y_ch, y_valid, busy, done);
`else
  modport master (output in, mode, sel_in, start, out_ready,
                  input  y, y_ch, y_valid, busy, done);
  modport slave  (input  in, mode, sel_in, start, out_ready,
                  output y, y_ch, y_valid, busy, done);
`endif

endinterface

// File: rtl/scan_mux_nx1_next_ch_find.sv
// -----------------------------------------------------------------------------
// next_ch_find
// Combinational priority search over a channel mask.
//   i_mask  : N-bit channel enable mask
//   i_idx   : current channel index
//   i_first : 1 = lowest set bit overall, 0 = lowest set bit strictly above i_idx
//   o_idx   : index found (0 when none)
//   o_found : a qualifying channel exists
// -----------------------------------------------------------------------------
module next_ch_find #(
  parameter int SEL_W = 3
) (
  input  logic [2**SEL_W-1:0] i_mask,
  input  logic [SEL_W-1:0]    i_idx,
  input  logic                i_first,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_found
);
  localparam int N = 2 ** SEL_W;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path
    // with no qualifying bit would leave it unassigned and infer a latch.
    o_idx   = '0;
    o_found = 1'b0;
    // Walk downward so the lowest qualifying channel is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_idx)))) begin
        o_found = 1'b1;
        o_idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/scan_mux_nx1.sv
// -----------------------------------------------------------------------------
// scan_mux_nx1
// N-to-1 multiplexer with registered output, valid/ready handshake and an
// automatic ascending channel scan. One start pulse delivers either the
// channel named by sel_in (manual) or every enabled channel (scan).
// Optional macro: SCAN_MASK_EN -- when defined, scan visits only channels
// whose en_mask bit was set at start; otherwise all N channels are visited.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : scan_mux_nx1_if.slave (data, controls, handshake and status)
// -----------------------------------------------------------------------------
module scan_mux_nx1
  import scan_mux_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
) (
  input  logic           clk,
  input  logic           rst,
  scan_mux_nx1_if.slave  bus
);
  localparam int N = 2 ** SEL_W;

  state_t              r_state;
  logic                r_mode;
  logic [N-1:0]        r_mask;
  logic [DATA_W-1:0]   r_y;
  logic [SEL_W-1:0]    r_y_ch;
  logic                r_y_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_idle;
  logic [N-1:0]        w_start_mask;
  logic [N-1:0]        w_find_mask;
  logic [SEL_W-1:0]    w_next_ch;
  logic                w_next_found;
  logic [SEL_W-1:0]    w_load_ch;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_accept;

`ifdef SCAN_MASK_EN
  assign w_start_mask = bus.en_mask;
`else
  assign w_start_mask = '1;
`endif

  assign w_idle = (r_state == IDLE);

  // One finder serves both phases: in IDLE it searches the incoming mask from
  // the bottom, in OUT it searches the latched mask above the current channel.
  assign w_find_mask = w_idle ? w_start_mask : r_mask;

  next_ch_find #(.SEL_W(SEL_W)) u_find (
    .i_mask  (w_find_mask),
    .i_idx   (r_y_ch),
    .i_first (w_idle),
    .o_idx   (w_next_ch),
    .o_found (w_next_found)
  );

  assign w_load_ch   = (w_idle && bus.mode == MODE_MANUAL) ? bus.sel_in : w_next_ch;
  assign w_load_data = bus.in[int'(w_load_ch) * DATA_W +: DATA_W];
  assign w_accept    = r_y_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the evaluation order inside the block is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= MODE_MANUAL;
      r_mask    <= '0;
      r_y       <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_mask <= w_start_mask;
            if (bus.mode == MODE_MANUAL || w_next_found) begin
              r_y       <= w_load_data;
              r_y_ch    <= w_load_ch;
              r_y_valid <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= OUT;
            end else begin
              // Empty scan mask: complete immediately without a beat.
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        OUT: begin
          if (w_accept) begin
            if (r_mode == MODE_SCAN && w_next_found) begin
              r_y    <= w_load_data;
              r_y_ch <= w_load_ch;
            end else begin
              r_y_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= FIN;
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.y_ch    = r_y_ch;
  assign bus.y_valid = r_y_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_scan_mux_nx1.sv
// -----------------------------------------------------------------------------
// tb_scan_mux_nx1
// Randomised bench for scan_mux_nx1 (SEL_W=3, DATA_W=8). The reference model
// is a queue of expected channel indices built from the mode/mask rules, with
// beat data taken from the channel values present at each loading edge.
// Optional macro: SCAN_MASK_EN enables the sparse and empty mask scenarios.
// -----------------------------------------------------------------------------
module tb_scan_mux_nx1;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;
  localparam int N      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_mux_nx1_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  scan_mux_nx1 #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] chv [N];
  for (genvar g = 0; g < N; g++) begin : g_in
    assign bus.in[g*DATA_W +: DATA_W] = chv[g];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef SCAN_MASK_EN
    return m;
`else
    return m | 8'hFF;
`endif
  endfunction

  // Runs one operation and checks every cycle against the queue model.
  task automatic run_op(input logic md, input logic [2:0] s, input logic [7:0] mk,
                        input int ready_pct, input bit inj_start, input string tag);
    int         exp_q[$];
    logic [7:0] em;
    logic [7:0] exp_d;
    int         k;
    int         beats;
    bit         acc;
    bit         timed_out;
    em = eff_mask(mk);
    if (md == 1'b0) exp_q.push_back(int'(s));
    else for (int i = 0; i < N; i++) if (em[i]) exp_q.push_back(i);
    k = exp_q.size();
    exp_d = (k > 0) ? chv[exp_q[0]] : 8'h00;
    bus.mode = md;
    bus.sel_in = s;
`ifdef SCAN_MASK_EN
    bus.en_mask = mk;
`endif
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    beats = 0;
    timed_out = 1'b0;
    while (exp_q.size() > 0) begin
      n_checks++;
      if (bus.y_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.y !== exp_d || bus.y_ch !== 3'(exp_q[0])) begin
        n_fail++;
        $display("FAIL %s beat%0d: got valid=%0b busy=%0b done=%0b y=%02h ch=%0d, expected valid=1 busy=1 done=0 y=%02h ch=%0d",
                 tag, beats, bus.y_valid, bus.busy, bus.done, bus.y, bus.y_ch, exp_d, exp_q[0]);
      end
      chv[$urandom_range(N-1)] = 8'($urandom);
      acc = ($urandom_range(99) < ready_pct);
      bus.out_ready = acc;
      bus.start = inj_start && ($urandom_range(1) == 1);
      bus.mode = 1'($urandom);
      bus.sel_in = 3'($urandom);
`ifdef SCAN_MASK_EN
      bus.en_mask = 8'($urandom);
`endif
      if (acc) begin
        void'(exp_q.pop_front());
        if (exp_q.size() > 0) exp_d = chv[exp_q[0]];
      end
      tick();
      beats++;
      if (beats > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: got %0d cycles without completion, expected at most 400", tag, beats);
        timed_out = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b0;
    bus.start = inj_start;
    if (!timed_out) begin
      n_checks++;
      if (bus.done !== 1'b1 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done: got done=%0b valid=%0b busy=%0b, expected done=1 valid=0 busy=0",
                 tag, bus.done, bus.y_valid, bus.busy);
      end
      if (ready_pct >= 100) begin
        n_checks++;
        if (beats !== k) begin
          n_fail++;
          $display("FAIL %s latency: got done after %0d beat cycles, expected %0d", tag, beats, k);
        end
      end
    end
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%0b valid=%0b busy=%0b, expected 0 0 0",
               tag, bus.done, bus.y_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got y=%02h ch=%0d valid=%0b busy=%0b done=%0b, expected all 0",
               bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) chv[i] = 8'h80 + 8'(i);
    bus.mode = 1'b0;
    bus.sel_in = 3'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_async: got y=%02h ch=%0d valid=%0b busy=%0b done=%0b, expected all 0",
               bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_manual();
    for (int i = 0; i < N; i++) chv[i] = 8'($urandom);
    chv[5] = 8'hA5;
    bus.mode = 1'b0;
    bus.sel_in = 3'd5;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.y !== 8'hA5 || bus.y_ch !== 3'd5 || bus.y_valid !== 1'b1 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL manual_hold%0d: got y=%02h ch=%0d valid=%0b busy=%0b, expected y=a5 ch=5 valid=1 busy=1",
                 c, bus.y, bus.y_ch, bus.y_valid, bus.busy);
      end
      chv[5] = 8'h30 + 8'(c);
      if (c < 3) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_done: got done=%0b valid=%0b busy=%0b, expected 1 0 0",
               bus.done, bus.y_valid, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_done_pulse: got done=%0b, expected 0", bus.done);
    end
  endtask

  task automatic test_full_scan();
    for (int i = 0; i < N; i++) chv[i] = 8'h10 + 8'(i);
    run_op(1'b1, 3'd0, 8'hFF, 100, 1'b0, "full_scan");
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_sparse_scan();
    for (int i = 0; i < N; i++) chv[i] = 8'(8'h40 + i);
    run_op(1'b1, 3'd0, 8'b1010_0100, 100, 1'b1, "sparse_scan");
  endtask

  task automatic test_empty_mask();
    run_op(1'b1, 3'd0, 8'h00, 100, 1'b1, "empty_mask");
  endtask
`endif

  task automatic test_reset_mid_scan();
    for (int i = 0; i < N; i++) chv[i] = 8'h20 + 8'(i);
    bus.mode = 1'b1;
`ifdef SCAN_MASK_EN
    bus.en_mask = 8'hFF;
`endif
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (bus.y_ch !== 3'd4 || bus.y !== 8'h24) begin
      n_fail++;
      $display("FAIL midscan_pos: got ch=%0d y=%02h, expected ch=4 y=24", bus.y_ch, bus.y);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done} !== 14'd0) begin
      n_fail++;
      $display("FAIL midscan_reset: got y=%02h ch=%0d valid=%0b busy=%0b done=%0b, expected all 0",
               bus.y, bus.y_ch, bus.y_valid, bus.busy, bus.done);
    end
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    run_op(1'b1, 3'd0, 8'hFF, 100, 1'b0, "restart_scan");
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) chv[i] = 8'($urandom);
      run_op(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(100, 30)),
             1'b1, $sformatf("random%0d", r));
    end
  endtask

  initial begin
    bus.mode = 1'b0;
    bus.sel_in = '0;
`ifdef SCAN_MASK_EN
    bus.en_mask = '0;
`endif
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) chv[i] = '0;
    test_reset();
    test_manual();
    test_full_scan();
`ifdef SCAN_MASK_EN
    test_sparse_scan();
    test_empty_mask();
`endif
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running at 2ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
